// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU: accept, execute, respond.
// Tie-break policy: define ALU_ARB_RR_EN for round-robin, otherwise port 0 has fixed priority.
module alu_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [3:0]       req0_sel,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [3:0]       req1_sel,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_result,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   input  logic             rsp_ready
);

   // state | meaning
   // IDLE  | waiting for a request; grant computed combinationally
   // EXEC  | latched operands drive the ALU; result captured at end of cycle
   // RESP  | rsp_valid high, response held until rsp_ready
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [3:0]       sel_q, sel_d;
   logic             id_q, id_d;
   logic             last_id_q, last_id_d;
   logic             rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

   logic gnt_vld;
   logic gnt_id;

   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = 1'b0;
      if (state_q == IDLE) begin
         if (req0_valid && req1_valid) begin
            gnt_vld = 1'b1;
`ifdef ALU_ARB_RR_EN
            gnt_id  = ~last_id_q;
`else
            gnt_id  = 1'b0;
`endif
         end else if (req0_valid) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b0;
         end else if (req1_valid) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b1;
         end
      end
   end

   // Readies are gated by rst_n so nothing appears accepted while reset is held.
   assign req0_ready = rst_n && gnt_vld && !gnt_id;
   assign req1_ready = rst_n && gnt_vld &&  gnt_id;

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      sel_d      = sel_q;
      id_d       = id_q;
      last_id_d  = last_id_q;
      rsp_id_d   = rsp_id_q;
      rsp_data_d = rsp_data_q;
      case (state_q)
         IDLE: begin
            if (gnt_vld) begin
               a_d     = gnt_id ? req1_a   : req0_a;
               b_d     = gnt_id ? req1_b   : req0_b;
               sel_d   = gnt_id ? req1_sel : req0_sel;
               id_d    = gnt_id;
               state_d = EXEC;
            end
         end
         EXEC: begin
            rsp_data_d = alu_result;
            rsp_id_d   = id_q;
            last_id_d  = id_q;
            state_d    = RESP;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         sel_q      <= '0;
         id_q       <= 1'b0;
         last_id_q  <= 1'b1;
         rsp_id_q   <= 1'b0;
         rsp_data_q <= '0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         sel_q      <= sel_d;
         id_q       <= id_d;
         last_id_q  <= last_id_d;
         rsp_id_q   <= rsp_id_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_sel   = sel_q;
   assign rsp_valid = (state_q == RESP);
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the shared port.
module tb_alu_arbiter;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0_valid, req1_valid;
   logic         req0_ready, req1_ready;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]   req0_sel, req1_sel;
   logic [W-1:0] alu_a, alu_b, alu_result;
   logic [3:0]   alu_sel;
   logic         rsp_valid, rsp_id, rsp_ready;
   logic [W-1:0] rsp_data;

   int n_checks = 0;
   int n_errors = 0;

   alu_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_ready(rsp_ready)
   );

   always #5 clk = ~clk;

   always_comb begin
      case (alu_sel)
         4'h0:    alu_result = alu_a + alu_b;
         4'h1:    alu_result = alu_a - alu_b;
         4'h2:    alu_result = alu_a & alu_b;
         4'h3:    alu_result = alu_a | alu_b;
         4'h4:    alu_result = alu_a ^ alu_b;
         default: alu_result = alu_a ^ alu_b ^ 32'hA5A5_A5A5;
      endcase
   end

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp(input string tag);
      int i;
      for (i = 0; i < 10; i++) begin
         if (rsp_valid) break;
         step();
      end
      if (i == 10) check_eq(tag, {31'd0, rsp_valid}, 32'd1);
   endtask

   task automatic apply_reset();
      #2 rst_n = 1'b0;
      step();
      step();
      #2 rst_n = 1'b1;
      step();
   endtask

   initial begin
      rst_n = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = '0; req0_b = '0; req0_sel = '0;
      req1_a = '0; req1_b = '0; req1_sel = '0;
      rsp_ready = 1'b0;
      #3;
      check_eq("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
      check_eq("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
      check_eq("rst_rsp_valid",  {31'd0, rsp_valid},  32'd0);
      check_eq("rst_rsp_data",   rsp_data, 32'd0);
      check_eq("rst_rsp_id",     {31'd0, rsp_id}, 32'd0);
      check_eq("rst_alu_a",      alu_a, 32'd0);
      check_eq("rst_alu_sel",    {28'd0, alu_sel}, 32'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      // Single req0 ADD 5+3
      req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_sel = 4'h0;
      rsp_ready = 1'b1;
      #1;
      check_eq("t1_req0_ready", {31'd0, req0_ready}, 32'd1);
      check_eq("t1_req1_ready", {31'd0, req1_ready}, 32'd0);
      step();
      req0_valid = 1'b0;
      check_eq("t1_exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_eq("t1_exec_alu_a", alu_a, 32'd5);
      check_eq("t1_exec_alu_b", alu_b, 32'd3);
      step();
      check_eq("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("t1_rsp_data", rsp_data, 32'd8);
      check_eq("t1_rsp_id", {31'd0, rsp_id}, 32'd0);
      step();
      check_eq("t1_idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);

      // Both valid continuously, four ops
      apply_reset();
      req0_a = 32'd10; req0_b = 32'd1; req0_sel = 4'h0;
      req1_a = 32'd20; req1_b = 32'd4; req1_sel = 4'h1;
      req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         logic exp_id;
`ifdef ALU_ARB_RR_EN
         exp_id = k[0];
`else
         exp_id = 1'b0;
`endif
         wait_rsp("t2_timeout");
         check_eq($sformatf("t2_rsp_id_%0d", k), {31'd0, rsp_id}, {31'd0, exp_id});
         check_eq($sformatf("t2_rsp_data_%0d", k), rsp_data, exp_id ? 32'd16 : 32'd11);
         step();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      step();
      step();

      // Back-pressure in RESP: req1 XOR 7^2
      req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd2; req1_sel = 4'h4;
      rsp_ready = 1'b0;
      #1;
      check_eq("t3_req1_ready", {31'd0, req1_ready}, 32'd1);
      step();
      req1_valid = 1'b0; req0_valid = 1'b1;
      wait_rsp("t3_timeout");
      for (int k = 0; k < 5; k++) begin
         check_eq("t3_hold_valid", {31'd0, rsp_valid}, 32'd1);
         check_eq("t3_hold_data", rsp_data, 32'd5);
         check_eq("t3_hold_id", {31'd0, rsp_id}, 32'd1);
         check_eq("t3_hold_rdy0", {31'd0, req0_ready}, 32'd0);
         check_eq("t3_hold_rdy1", {31'd0, req1_ready}, 32'd0);
         step();
      end
      rsp_ready = 1'b1;
      step();
      check_eq("t3_done_valid", {31'd0, rsp_valid}, 32'd0);
      check_eq("t3_idle_rdy0", {31'd0, req0_ready}, 32'd1);
      req0_valid = 1'b0;
      step();
      step();
      check_eq("t3_withdraw_alu_a", alu_a, 32'd7);
      check_eq("t3_withdraw_valid", {31'd0, rsp_valid}, 32'd0);

      // Reset during EXEC; preceding req0 op leaves last_id=0
      req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_sel = 4'h0;
      step();
      req0_valid = 1'b0;
      wait_rsp("t4a_timeout");
      step();
      req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9; req1_sel = 4'h0;
      step();
      req1_valid = 1'b0;
      check_eq("t4_exec_alu_a", alu_a, 32'd9);
      #2 rst_n = 1'b0;
      #1;
      check_eq("t4_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_eq("t4_rst_alu_a", alu_a, 32'd0);
      step();
      #2 rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check_eq("t4_no_rsp", {31'd0, rsp_valid}, 32'd0);
      end
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = 32'd2; req0_b = 32'd2;
      #1;
      check_eq("t4_grant_rdy0", {31'd0, req0_ready}, 32'd1);
      check_eq("t4_grant_rdy1", {31'd0, req1_ready}, 32'd0);
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_rsp("t4b_timeout");
      check_eq("t4_post_rsp_id", {31'd0, rsp_id}, 32'd0);
      check_eq("t4_post_rsp_data", rsp_data, 32'd4);
      step();

      // Undefined sel passes through unchanged
      req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'h1234_5678; req1_sel = 4'hF;
      step();
      req1_valid = 1'b0;
      check_eq("t5_exec_alu_sel", {28'd0, alu_sel}, 32'h0000_000F);
      check_eq("t5_exec_alu_result", alu_result, 32'h486E_0C22);
      step();
      check_eq("t5_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("t5_rsp_data", rsp_data, 32'h486E_0C22);
      check_eq("t5_rsp_id", {31'd0, rsp_id}, 32'd1);
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands of requester N.
REQ-007 req0_sel / req1_sel  input  4  ALU select code of requester N (same encoding as ALUsel).
REQ-008 alu_a, alu_b  output  WIDTH  operands to shared combinational ALU.
REQ-009 alu_sel  output  4  select code to shared ALU.
REQ-010 alu_result  input  WIDTH  combinational result from shared ALU.
REQ-011 rsp_valid  output  1  result available.
REQ-012 rsp_id  output  1  requester index owning rsp_data.
REQ-013 rsp_data  output  WIDTH  registered ALU result.
REQ-014 rsp_ready  input  1  consumer accepts response.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, EXEC, RESP.
REQ-016 The grant SHALL be computed combinationally in IDLE: only one valid -> that port; both valid -> per REQ-034/035; none -> no grant.
REQ-017 reqN_ready SHALL be 1 only when state==IDLE and grant==N; both readies SHALL never be 1 together.
REQ-018 On valid&&ready for port N, the block SHALL latch a, b, sel, id=N and move to EXEC next cycle.
REQ-019 alu_a, alu_b, alu_sel SHALL always drive the latched operand registers (stable through EXEC).
REQ-020 In EXEC the block SHALL capture alu_result into rsp_data, store rsp_id, update last_id=id, and move to RESP.
REQ-021 In RESP rsp_valid SHALL be 1, with rsp_data and rsp_id held stable until rsp_ready==1.
REQ-022 On rsp_valid&&rsp_ready the block SHALL return to IDLE; a new accept SHALL occur no earlier than the following cycle.
REQ-023 Latency: accept at cycle T -> rsp_valid at T+2; maximum throughput 1 op per 3 cycles.
REQ-024 Deassertion of reqN_valid before acceptance SHALL be legal and SHALL cause no grant and no state change.
REQ-025 sel codes SHALL be passed to alu_sel unmodified, including undefined codes.
REQ-026 rsp_ready while rsp_valid==0 SHALL be ignored.

Reset
REQ-027 rst_n low SHALL asynchronously force state=IDLE, last_id=1, rsp_valid=0, rsp_id=0, rsp_data=0.
REQ-028 rst_n low SHALL asynchronously clear latched alu_a, alu_b, alu_sel to 0.
REQ-029 req0_ready and req1_ready SHALL be 0 while rst_n is low.
REQ-030 Reset asserted in EXEC or RESP SHALL discard the in-flight operation with no response produced.
REQ-031 The first grant after reset with both requesters valid SHALL go to port 0.
REQ-032 Release of rst_n SHALL take effect on the next rising clk edge only.

Configuration
REQ-033 Macro ALU_ARB_RR_EN SHALL select the tie-break policy at compile time.
REQ-034 With ALU_ARB_RR_EN defined: when both requesters are valid, grant SHALL go to the port != last_id (round-robin).
REQ-035 Without ALU_ARB_RR_EN: when both requesters are valid, port 0 SHALL always win (fixed priority); last_id SHALL still be maintained.

Verification
REQ-036 req0 only, a=5, b=3, sel=ADD, rsp_ready=1 -> req0_ready at T, rsp_valid at T+2, rsp_data=8, rsp_id=0, IDLE at T+3.
REQ-037 Both valid continuously, 4 ops, RR_EN defined -> rsp_id sequence 0,1,0,1; without RR_EN -> 0,0,0,0.
REQ-038 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_data, rsp_id stable; req ready both 0; completes on rsp_ready=1.
REQ-039 rst_n pulsed low during EXEC -> rsp_valid=0 immediately, no response for that op, next both-valid grant goes to port 0.
REQ-040 req1 sel=4'hF (undefined), a=0xFFFFFFFF -> alu_sel=4'hF during EXEC, rsp_data equals alu_result sampled in EXEC.
